// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one word-wide frame-buffer memory port between
// the camera write stream and the display read stream. It keeps a wrapping
// word pointer per stream, arbitrates round-robin with per-stream burst
// quotas, and holds reads off for a while after reset.
module frame_mem_arbiter #(
   parameter int FRAME_WORDS    = 307200,
   parameter int WR_QUOTA       = 8,
   parameter int RD_QUOTA       = 8,
   parameter int RD_START_DELAY = 64
) (
   input  logic        ctrl_clk,
   input  logic        reset_n,
   input  logic        wr_req,
   input  logic [31:0] wr_data,
   output logic        wr_ack,
   input  logic        rd_enable,
   input  logic        rd_full,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_waitrequest,
   output logic        wr_frame_done,
   output logic        rd_frame_done
);

   localparam int PTR_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int MAX_Q = (WR_QUOTA > RD_QUOTA) ? WR_QUOTA : RD_QUOTA;
   localparam int CNT_W = $clog2(MAX_Q + 1);
   localparam int DLY_W = (RD_START_DELAY > 1) ? $clog2(RD_START_DELAY + 1) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FRAME_WORDS - 1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] WR_QUOTA_C = CNT_W'(WR_QUOTA);
   localparam logic [CNT_W-1:0] RD_QUOTA_C = CNT_W'(RD_QUOTA);
   localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(RD_START_DELAY - 1);
   localparam logic [DLY_W-1:0] DLY_ONE    = DLY_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_e;

   state_e             state_q, state_d;
   grant_e             last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DLY_W-1:0]   delay_cnt_q;
   logic               delay_done_q;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               mem_write_q, mem_write_d;
   logic               mem_read_q, mem_read_d;
   logic               wr_frame_done_q, wr_frame_done_d;
   logic               rd_frame_done_q, rd_frame_done_d;

   logic               wr_elig;
   logic               rd_elig;
   logic               wr_accept;
   logic               rd_accept;
   logic               last_elig;
   logic               other_elig;
   grant_e             other_grant;
   logic [CNT_W-1:0]   last_quota;
   logic               grant_valid;
   grant_e             grant_sel;
   logic [CNT_W-1:0]   burst_next;

   function automatic logic [31:0] ptr_to_addr(input logic [PTR_W-1:0] ptr);
      return {{(32-PTR_W-2){1'b0}}, ptr, 2'b00};
   endfunction

   function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
   endfunction

   assign wr_elig   = wr_req;
   assign rd_elig   = rd_enable & ~rd_full & delay_done_q;
   assign wr_accept = mem_write_q & ~mem_waitrequest;
   assign rd_accept = mem_read_q & ~mem_waitrequest;

   assign wr_ack        = wr_accept;
   assign rd_valid      = rd_accept;
   assign rd_data       = mem_rdata;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_write     = mem_write_q;
   assign mem_read      = mem_read_q;
   assign wr_frame_done = wr_frame_done_q;
   assign rd_frame_done = rd_frame_done_q;

   // Read holdoff: count cycles after reset until the display path may start.
   always_ff @(posedge ctrl_clk or negedge reset_n) begin
      if (!reset_n) begin
         delay_cnt_q  <= '0;
         delay_done_q <= 1'b0;
      end else if (!delay_done_q) begin
         if (delay_cnt_q == DLY_LAST) begin
            delay_done_q <= 1'b1;
         end else begin
            delay_cnt_q <= delay_cnt_q + DLY_ONE;
         end
      end
   end

   // Round-robin grant choice; a zero burst count means nothing was granted
   // yet, so the first tie falls to the stream opposite the reset last_grant.
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = last_grant_q;
      burst_next  = burst_cnt_q;
      if (last_grant_q == GNT_RD) begin
         last_elig   = rd_elig;
         other_elig  = wr_elig;
         other_grant = GNT_WR;
         last_quota  = RD_QUOTA_C;
      end else begin
         last_elig   = wr_elig;
         other_elig  = rd_elig;
         other_grant = GNT_RD;
         last_quota  = WR_QUOTA_C;
      end
      if (last_elig && (burst_cnt_q != '0) && (burst_cnt_q < last_quota)) begin
         grant_valid = 1'b1;
         grant_sel   = last_grant_q;
         burst_next  = burst_cnt_q + CNT_ONE;
      end else if (other_elig) begin
         grant_valid = 1'b1;
         grant_sel   = other_grant;
         burst_next  = CNT_ONE;
      end else if (last_elig) begin
         grant_valid = 1'b1;
         grant_sel   = last_grant_q;
         burst_next  = CNT_ONE;
      end
   end

   // Transfer FSM: issue the granted command, hold it through waitrequest,
   // then drop back to IDLE for one bubble cycle before re-arbitrating.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      burst_cnt_d     = burst_cnt_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      mem_write_d     = mem_write_q;
      mem_read_d      = mem_read_q;
      wr_frame_done_d = 1'b0;
      rd_frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            if (grant_valid) begin
               last_grant_d = grant_sel;
               burst_cnt_d  = burst_next;
               if (grant_sel == GNT_WR) begin
                  state_d     = WR;
                  mem_addr_d  = ptr_to_addr(wr_ptr_q);
                  mem_wdata_d = wr_data;
                  mem_write_d = 1'b1;
               end else begin
                  state_d    = RD;
                  mem_addr_d = ptr_to_addr(rd_ptr_q);
                  mem_read_d = 1'b1;
               end
            end
         end
         WR: begin
            if (wr_accept) begin
               state_d         = IDLE;
               mem_write_d     = 1'b0;
               wr_ptr_d        = ptr_advance(wr_ptr_q);
               wr_frame_done_d = (wr_ptr_q == PTR_LAST);
            end
         end
         RD: begin
            if (rd_accept) begin
               state_d         = IDLE;
               mem_read_d      = 1'b0;
               rd_ptr_d        = ptr_advance(rd_ptr_q);
               rd_frame_done_d = (rd_ptr_q == PTR_LAST);
            end
         end
         default: begin
            state_d     = IDLE;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears commands immediately.
   always_ff @(posedge ctrl_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         last_grant_q    <= GNT_RD;
         burst_cnt_q     <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         wr_frame_done_q <= 1'b0;
         rd_frame_done_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         burst_cnt_q     <= burst_cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         wr_frame_done_q <= wr_frame_done_d;
         rd_frame_done_q <= rd_frame_done_d;
      end
   end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed checks of the frame memory arbiter with a
// small frame, short quotas and a short read holdoff.
module tb_frame_mem_arbiter;

   logic        ctrl_clk;
   logic        reset_n;
   logic        wr_req;
   logic [31:0] wr_data;
   logic        wr_ack;
   logic        rd_enable;
   logic        rd_full;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_waitrequest;
   logic        wr_frame_done;
   logic        rd_frame_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   frame_mem_arbiter #(
      .FRAME_WORDS   (16),
      .WR_QUOTA      (4),
      .RD_QUOTA      (2),
      .RD_START_DELAY(8)
   ) dut (
      .ctrl_clk       (ctrl_clk),
      .reset_n        (reset_n),
      .wr_req         (wr_req),
      .wr_data        (wr_data),
      .wr_ack         (wr_ack),
      .rd_enable      (rd_enable),
      .rd_full        (rd_full),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .mem_addr       (mem_addr),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_waitrequest(mem_waitrequest),
      .wr_frame_done  (wr_frame_done),
      .rd_frame_done  (rd_frame_done)
   );

   // Memory returns a word tagged with the address it was read from.
   assign mem_rdata = 32'hA500_0000 | mem_addr;

   initial ctrl_clk = 1'b0;
   always #5 ctrl_clk = ~ctrl_clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wrReq, input logic [31:0] wrData, input logic rdEnable,
                                input logic rdFull, input logic waitReq);
      wr_req          = wrReq;
      wr_data         = wrData;
      rd_enable       = rdEnable;
      rd_full         = rdFull;
      mem_waitrequest = waitReq;
   endtask

   task automatic tick();
      @(posedge ctrl_clk);
      #1;
      cyc++;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      repeat (2) @(posedge ctrl_clk);
      @(negedge ctrl_clk);
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic nextGrant(input string tag, output logic isWr, output logic [31:0] addr,
                            output logic [31:0] wdata);
      logic found;
      found = 1'b0;
      isWr  = 1'b0;
      addr  = '0;
      wdata = '0;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (mem_write || mem_read) begin
            found = 1'b1;
            isWr  = mem_write;
            addr  = mem_addr;
            wdata = mem_wdata;
         end
      end
      checkOutput({tag, " found"}, 32'(found), 32'd1);
      if (found) checkOutput({tag, " exclusive"}, 32'(mem_write & mem_read), 32'd0);
   endtask

   initial begin
      logic        isWr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        sawRead;
      logic [11:0] patW;
      int          firstReadCyc;

      reset_n = 1'b0;

      // 1: writes only, wrap through one 16-word frame
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      doReset();
      checkOutput("reset mem_write", 32'(mem_write), 32'd0);
      checkOutput("reset mem_read", 32'(mem_read), 32'd0);
      checkOutput("reset mem_addr", mem_addr, 32'd0);
      checkOutput("reset wr_ack", 32'(wr_ack), 32'd0);
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset frame_done", 32'({wr_frame_done, rd_frame_done}), 32'd0);
      for (int i = 0; i < 17; i++) begin
         tick();
         checkOutput("t1 mem_write", 32'(mem_write), 32'd1);
         checkOutput("t1 mem_addr", mem_addr, 32'((i % 16) * 4));
         checkOutput("t1 mem_wdata", mem_wdata, 32'(32'h100 + i));
         checkOutput("t1 wr_ack", 32'(wr_ack), 32'd1);
         tick();
         wr_data = 32'(32'h100 + i + 1);
         checkOutput("t1 bubble", 32'(mem_write), 32'd0);
         checkOutput("t1 wr_frame_done", 32'(wr_frame_done), 32'(i == 15));
      end

      // 2: reads only, holdoff then sequential addresses
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      doReset();
      sawRead = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         sawRead = sawRead | mem_read | rd_valid;
      end
      checkOutput("t2 holdoff", 32'(sawRead), 32'd0);
      for (int i = 0; i < 3; i++) begin
         nextGrant("t2 read", isWr, addr, wdata);
         if (i == 0) checkOutput("t2 first read cycle>=8", 32'(cyc >= 8), 32'd1);
         checkOutput("t2 is read", 32'(isWr), 32'd0);
         checkOutput("t2 addr", addr, 32'(i * 4));
         checkOutput("t2 rd_valid", 32'(rd_valid), 32'd1);
         checkOutput("t2 rd_data", rd_data, 32'hA500_0000 | 32'(i * 4));
         tick();
         checkOutput("t2 bubble", 32'({mem_read, rd_valid}), 32'd0);
      end

      // 3: both streams eligible together, quota pattern
      applyStimulus(1'b0, 32'h400, 1'b0, 1'b0, 1'b0);
      doReset();
      repeat (12) tick();
      applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
      patW = 12'h3CF;
      for (int g = 0; g < 12; g++) begin
         nextGrant("t3 grant", isWr, addr, wdata);
         checkOutput($sformatf("t3 grant%0d is write", g), 32'(isWr), 32'(patW[g]));
         tick();
      end

      // 4: write stalled five cycles by waitrequest
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
      doReset();
      tick();
      wr_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t4 hold mem_write", 32'(mem_write), 32'd1);
         checkOutput("t4 hold mem_addr", mem_addr, 32'd0);
         checkOutput("t4 hold mem_wdata", mem_wdata, 32'h200);
         checkOutput("t4 hold wr_ack", 32'(wr_ack), 32'd0);
         tick();
      end
      mem_waitrequest = 1'b0;
      #1;
      checkOutput("t4 accept mem_write", 32'(mem_write), 32'd1);
      checkOutput("t4 accept wr_ack", 32'(wr_ack), 32'd1);
      tick();
      wr_data = 32'h201;
      checkOutput("t4 bubble", 32'({mem_write, wr_ack}), 32'd0);
      tick();
      checkOutput("t4 next mem_write", 32'(mem_write), 32'd1);
      checkOutput("t4 next mem_addr", mem_addr, 32'h4);
      checkOutput("t4 next mem_wdata", mem_wdata, 32'h201);

      // 5: read FIFO fills during a stalled read, writes keep flowing
      applyStimulus(1'b0, 32'h300, 1'b1, 1'b0, 1'b1);
      doReset();
      nextGrant("t5 first read", isWr, addr, wdata);
      checkOutput("t5 first is read", 32'(isWr), 32'd0);
      checkOutput("t5 first addr", addr, 32'd0);
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
      #1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("t5 stall mem_read", 32'(mem_read), 32'd1);
         checkOutput("t5 stall rd_valid", 32'(rd_valid), 32'd0);
         checkOutput("t5 stall mem_write", 32'(mem_write), 32'd0);
      end
      mem_waitrequest = 1'b0;
      #1;
      checkOutput("t5 accept rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("t5 accept rd_data", rd_data, 32'hA500_0000);
      tick();
      checkOutput("t5 bubble", 32'({mem_read, rd_valid}), 32'd0);
      for (int k = 0; k < 4; k++) begin
         nextGrant("t5 write", isWr, addr, wdata);
         checkOutput("t5 is write", 32'(isWr), 32'd1);
         checkOutput("t5 write addr", addr, 32'(k * 4));
         if (k == 3) rd_full = 1'b0;
         tick();
      end
      nextGrant("t5 resumed read", isWr, addr, wdata);
      checkOutput("t5 resumed is read", 32'(isWr), 32'd0);
      checkOutput("t5 resumed addr", addr, 32'h4);

      // 6: reset asserted under a stalled read
      applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
      doReset();
      for (int k = 0; k < 4; k++) begin
         nextGrant("t6 write", isWr, addr, wdata);
         checkOutput("t6 is write", 32'(isWr), 32'd1);
         tick();
      end
      nextGrant("t6 read0", isWr, addr, wdata);
      checkOutput("t6 read0 is read", 32'(isWr), 32'd0);
      checkOutput("t6 read0 addr", addr, 32'd0);
      wr_req = 1'b0;
      tick();
      nextGrant("t6 read1", isWr, addr, wdata);
      checkOutput("t6 read1 addr", addr, 32'h4);
      mem_waitrequest = 1'b1;
      tick();
      checkOutput("t6 stalled mem_read", 32'(mem_read), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t6 async mem_read", 32'(mem_read), 32'd0);
      checkOutput("t6 async rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("t6 async mem_write", 32'(mem_write), 32'd0);
      applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
      doReset();
      firstReadCyc = -1;
      for (int k = 0; k < 4; k++) begin
         nextGrant("t6 post write", isWr, addr, wdata);
         checkOutput("t6 post is write", 32'(isWr), 32'd1);
         checkOutput("t6 post write addr", addr, 32'(k * 4));
         tick();
      end
      nextGrant("t6 post read", isWr, addr, wdata);
      firstReadCyc = cyc;
      checkOutput("t6 post is read", 32'(isWr), 32'd0);
      checkOutput("t6 post read addr", addr, 32'd0);
      checkOutput("t6 holdoff repeats", 32'(firstReadCyc >= 8), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Shares the single word-wide frame-buffer memory port of the bus_sys system between two requesters, all in the ctrl_clk domain.
  - Write requester: D5M write FIFO (show-ahead read side).
  - Read requester: DVI read FIFO (write side).
- Generates independent wrapping frame addresses for each stream.
- Enforces round-robin arbitration with per-stream burst quotas and a startup read holdoff.

Parameters:
- FRAME_WORDS, 307200, words per frame (640*480); pointers wrap after FRAME_WORDS-1.
- WR_QUOTA, 8, max consecutive write grants while reads are eligible.
- RD_QUOTA, 8, max consecutive read grants while writes are eligible.
- RD_START_DELAY, 64, ctrl_clk cycles after reset before reads become eligible.

Ports:
- ctrl_clk  in  1  sole clock.
- reset_n  in  1  reset.
- wr_req  in  1  write FIFO not empty; wr_data valid while high.
- wr_data  in  32  write FIFO q (show-ahead).
- wr_ack  out  1  one-cycle pop of write FIFO.
- rd_enable  in  1  display read path enabled.
- rd_full  in  1  read FIFO full/almost-full.
- rd_data  out  32  read word to read FIFO.
- rd_valid  out  1  read FIFO wrreq.
- mem_addr  out  32  byte address (word index * 4).
- mem_write  out  1  write command.
- mem_read  out  1  read command.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- mem_waitrequest  in  1  memory stall.
- wr_frame_done  out  1  pulse when write pointer wraps.
- rd_frame_done  out  1  pulse when read pointer wraps.

Behaviour:
- Clocking and reset: one clock (ctrl_clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - All registered outputs are 0; state IDLE.
  - wr_ptr, rd_ptr, burst count and delay counter are 0.
  - last_grant = READ, so the first tie goes to the write stream.
- Async reset mid-command drops mem_write/mem_read immediately. No completion, no wr_ack, no rd_valid.
- Eligibility (sampled in IDLE only):
  - wr_elig = wr_req.
  - rd_elig = rd_enable & ~rd_full & delay_done.
  - delay_done sets after RD_START_DELAY cycles and stays set until reset.
- States: IDLE, WR, RD.
- IDLE, grant decision:
  - (a) If last_grant stream is eligible and burst_cnt < its quota, grant it again and increment burst_cnt.
  - (b) Otherwise, if the other stream is eligible, grant it with burst_cnt=1.
  - (c) Otherwise, if the last stream is eligible, grant it with burst_cnt=1.
  - (d) Otherwise, stay in IDLE.
- On grant, registered next cycle:
  - WR grant: mem_addr=wr_ptr*4, mem_wdata=wr_data (captured in IDLE), mem_write=1.
  - RD grant: mem_addr=rd_ptr*4, mem_read=1.
- WR/RD states:
  - Command, address and data held constant while mem_waitrequest=1.
  - Accept = command high & mem_waitrequest=0.
  - On accept, the command deasserts the next cycle and the state returns to IDLE.
  - This gives one mandatory bubble cycle per transfer, so the show-ahead FIFO status settles before re-arbitration.
- Write accept:
  - wr_ack=1 for exactly that cycle.
  - wr_ptr increments; if wr_ptr==FRAME_WORDS-1, it becomes 0 and wr_frame_done pulses the next cycle.
- Read accept:
  - rd_valid = mem_read & ~mem_waitrequest (combinational); rd_data = mem_rdata passthrough.
  - rd_ptr increments and wraps as above, with rd_frame_done.
- Never issues mem_write and mem_read together. Never issues a command outside WR/RD.
- Eligibility changes during WR/RD have no effect until IDLE. rd_full must therefore reserve at least 1 word of headroom.
- Throughput: at most one transfer per 2 cycles with zero waitrequest.

Test Plan:
Bench parameters: FRAME_WORDS=16, WR_QUOTA=4, RD_QUOTA=2, RD_START_DELAY=8.
1. Reset, wr_req=1 with data 0x100+n, rd_enable=0.
   -> mem_write on every other cycle; addresses 0x0,0x4,…,0x3C then 0x0.
   -> wr_ack pulse per accept; wr_frame_done pulses once after the 16th write.
2. rd_enable=1 and wr_req=0 from reset.
   -> No mem_read before cycle 8.
   -> Then reads at 0x0,0x4,…; rd_valid=1 exactly on accept cycles with rd_data==mem_rdata.
3. Both streams always eligible after the delay.
   -> Grant pattern W,W,W,W,R,R,W,W,W,W,R,R…; first grant after the tie is W.
4. mem_waitrequest held high for 5 cycles on a write.
   -> mem_write, mem_addr and mem_wdata stable for 5 cycles.
   -> Single wr_ack on the 6th cycle; wr_ptr advances by 1 only.
5. rd_full asserted while a read is stalled.
   -> The stalled read completes with one rd_valid.
   -> No further mem_read until rd_full=0; writes continue being granted meanwhile.
6. reset_n low mid-read with waitrequest high.
   -> mem_read=0 asynchronously; no rd_valid.
   -> After release, both pointers restart at 0 and the read holdoff repeats.
